step_pulse_gen: RTL and testbench

Synthetic step source for the pedometer datapath. Generates a clean step pulse train at a selectable, exactly-metered rate (walk/jog/run/hybrid), together with the 1 Hz `second_clk` that the downstream over-32-steps-per-second counter samples on its falling edge. The block sits directly upstream of that counter, and also upstream of the step/distance accumulators. Pulse windows are aligned so that every 1-second window contains exactly the programmed number of pulses and ends on a `second_clk` falling edge.

---
 rtl/step_pulse_gen_if.sv | 27 ++
 rtl/step_pulse_gen.sv | 131 +++++++++++++
 tb/tb_step_pulse_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if
// Bundles the control inputs and step/timing outputs of step_pulse_gen.
//   mode        : 2-bit rate select (00 walk, 01 jog, 10 run, 11 hybrid)
//   start       : level enable for the generator
//   pulse       : one-cycle step strobe
//   second_clk  : 1 Hz square wave, falling edge marks the window boundary
//   second_tick : one-cycle strobe on the first cycle of each window
//   rate        : pulses programmed for the current window
// Modports: master drives mode/start (stimulus side), slave is the generator.
interface step_pulse_gen_if;
    logic [1:0] mode;
    logic       start;
    logic       pulse;
    logic       second_clk;
    logic       second_tick;
    logic [7:0] rate;

    modport master (
        output mode, start,
        input  pulse, second_clk, second_tick, rate
    );

    modport slave (
        input  mode, start,
        output pulse, second_clk, second_tick, rate
    );
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
// Synthetic step source: emits exactly `rate` evenly metered pulses per
// CLK_HZ-cycle window, plus a 1 Hz second_clk whose falling edge ends
// each window and a second_tick strobe on the first cycle of each window.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : step_pulse_gen_if.slave (mode/start in; pulse/second_clk/
//           second_tick/rate out, all registered)
module step_pulse_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    step_pulse_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_FIXED,
        ST_HYBRID
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_sec_cnt;
    logic [31:0] w_sec_nxt;
    logic [31:0] r_acc;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_sum;
    logic [3:0]  r_hidx;
    logic [3:0]  w_hidx_nxt;
    logic [7:0]  r_rate;
    logic [7:0]  w_rate_nxt;
    logic        r_pulse;
    logic        r_second_clk;
    logic        r_second_tick;
    logic        w_wrap;
    logic        w_pulse_nxt;

    function automatic logic [7:0] f_hyb(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'd20;
            4'd1:    return 8'd33;
            4'd2:    return 8'd66;
            4'd3:    return 8'd27;
            4'd4:    return 8'd70;
            4'd5:    return 8'd30;
            4'd6:    return 8'd19;
            4'd7:    return 8'd30;
            4'd8:    return 8'd33;
            default: return 8'd69;
        endcase
    endfunction

    function automatic logic [7:0] f_fixed(input logic [1:0] m);
        case (m)
            2'b00:   return 8'd32;
            2'b01:   return 8'd64;
            default: return 8'd128;
        endcase
    endfunction

    always_comb begin
        w_wrap      = (r_sec_cnt == CLK_HZ - 1);
        w_sec_nxt   = w_wrap ? '0 : r_sec_cnt + 32'd1;
        w_state_nxt = r_state;
        w_hidx_nxt  = r_hidx;
        w_rate_nxt  = r_rate;

        // mode/start are only looked at on the last cycle of a window
        if (w_wrap) begin
            if (!bus.start) begin
                w_state_nxt = ST_STOP;
                w_rate_nxt  = '0;
            end else if (bus.mode == 2'b11) begin
                w_state_nxt = ST_HYBRID;
                if (r_state != ST_HYBRID)
                    w_hidx_nxt = '0;
                else if (r_hidx != 4'd9)
                    w_hidx_nxt = r_hidx + 4'd1;
                w_rate_nxt = f_hyb(w_hidx_nxt);
            end else begin
                w_state_nxt = ST_FIXED;
                w_rate_nxt  = f_fixed(bus.mode);
            end
        end

        w_sum = r_acc + {24'd0, r_rate};
        if (w_wrap || r_state == ST_STOP)
            w_acc_nxt = '0;
        else if (w_sum >= CLK_HZ)
            w_acc_nxt = w_sum - CLK_HZ;
        else
            w_acc_nxt = w_sum;

        // Overflow test is evaluated one cycle ahead on next-cycle state so
        // that pulse comes straight from a flop yet lines up with the
        // accumulator overflow of the cycle it is presented in.
        w_pulse_nxt = (w_state_nxt != ST_STOP) &&
                      ((w_acc_nxt + {24'd0, w_rate_nxt}) >= CLK_HZ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_STOP;
            r_sec_cnt     <= '0;
            r_acc         <= '0;
            r_hidx        <= '0;
            r_rate        <= '0;
            r_pulse       <= 1'b0;
            r_second_clk  <= 1'b0;
            r_second_tick <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sec_cnt     <= w_sec_nxt;
            r_acc         <= w_acc_nxt;
            r_hidx        <= w_hidx_nxt;
            r_rate        <= w_rate_nxt;
            r_pulse       <= w_pulse_nxt;
            r_second_clk  <= (w_sec_nxt >= CLK_HZ / 2);
            r_second_tick <= (w_sec_nxt == '0);
        end
    end

    assign bus.pulse       = r_pulse;
    assign bus.second_clk  = r_second_clk;
    assign bus.second_tick = r_second_tick;
    assign bus.rate        = r_rate;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen
// Directed stimulus for step_pulse_gen with CLK_HZ = 1000. The stimulus
// process queues the expected rate of every window it expects to complete;
// a monitor measures each window (closed by second_tick) and compares.
module tb_step_pulse_gen;
    localparam int HZ = 1000;

    logic clk = 1'b0;
    logic reset;

    step_pulse_gen_if bus ();

    step_pulse_gen #(.CLK_HZ(HZ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rate;
        bit hyb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   over32 = 0;

    // monitor state
    bit   m_open = 1'b0;
    bit   m_prevp = 1'b0;
    bit   m_rchg = 1'b0;
    int   m_pos = 0;
    int   m_cnt = 0;
    int   m_hi = 0;
    int   m_first = -1;
    int   m_last = -1;
    int   m_adj = 0;
    int   m_r0 = 0;
    int   m_win = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int rate, input bit hyb);
        exp_t e;
        e.rate = rate;
        e.hyb  = hyb;
        q.push_back(e);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.second_tick && n < 2 * HZ);
        if (!bus.second_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout %s actual=none required=second_tick", tag);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"}, int'(bus.pulse), 0);
        check({tag, "_second_clk"}, int'(bus.second_clk), 0);
        check({tag, "_second_tick"}, int'(bus.second_tick), 0);
        check({tag, "_rate"}, int'(bus.rate), 0);
    endtask

    task automatic close_window();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL win%0d_unexpected actual=window required=none", m_win);
        end else begin
            e = q.pop_front();
            check($sformatf("win%0d_rate", m_win), m_rchg ? -1 : m_r0, e.rate);
            check($sformatf("win%0d_count", m_win), m_cnt, e.rate);
            check($sformatf("win%0d_clk_high", m_win), m_hi, HZ / 2);
            check($sformatf("win%0d_length", m_win), m_pos + 1, HZ);
            check($sformatf("win%0d_adjacent", m_win), m_adj, 0);
            if (e.rate > 0) begin
                check($sformatf("win%0d_first", m_win), m_first, (HZ + e.rate - 1) / e.rate - 1);
                check($sformatf("win%0d_last", m_win), m_last, HZ - 1);
            end else begin
                check($sformatf("win%0d_first", m_win), m_first, -1);
            end
            if (e.hyb && m_cnt > 32)
                over32++;
        end
        m_win++;
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset || bus.second_tick) begin
                // a reset abandons the window in flight without scoring it
                if (!reset && m_open)
                    close_window();
                m_open  = 1'b1;
                m_pos   = 0;
                m_cnt   = 0;
                m_hi    = 0;
                m_first = -1;
                m_last  = -1;
                m_adj   = 0;
                m_prevp = 1'b0;
                m_rchg  = 1'b0;
                m_r0    = int'(bus.rate);
            end else begin
                m_pos++;
            end
            if (m_open) begin
                if (bus.pulse) begin
                    m_cnt++;
                    if (m_first < 0)
                        m_first = m_pos;
                    m_last = m_pos;
                    if (m_prevp)
                        m_adj++;
                end
                m_prevp = bus.pulse;
                if (bus.second_clk)
                    m_hi++;
                if (int'(bus.rate) != m_r0)
                    m_rchg = 1'b1;
            end
        end
    end

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        reset     = 1'b1;
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        push(0, 1'b0);
        push(32, 1'b0);
        push(32, 1'b0);
        push(32, 1'b0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 reset = 1'b0;

        wait_tick("w1");
        wait_tick("w2");
        wait_tick("w3");
        #1 bus.mode = 2'b01;
        push(64, 1'b0);
        wait_tick("w4");
        #1 bus.mode = 2'b10;
        push(128, 1'b0);
        wait_tick("w5");
        #1 bus.mode = 2'b11;
        push(20, 1'b1); push(33, 1'b1); push(66, 1'b1); push(27, 1'b1);
        push(70, 1'b1); push(30, 1'b1); push(19, 1'b1); push(30, 1'b1);
        push(33, 1'b1); push(69, 1'b1); push(69, 1'b0); push(69, 1'b0);
        for (int i = 0; i < 12; i++)
            wait_tick("hybrid");
        #1 bus.mode = 2'b00;
        push(32, 1'b0);
        wait_tick("w18");
        #1 check("over32_count", over32, 5);
        bus.mode = 2'b11;
        push(20, 1'b0);
        wait_tick("w19");
        #1 bus.mode = 2'b00;
        push(32, 1'b0);

        // mid-window mode change only affects the following window
        wait_tick("w20");
        repeat (400) @(negedge clk);
        #1 bus.mode = 2'b10;
        push(128, 1'b0);
        wait_tick("w21");
        repeat (300) @(negedge clk);
        #1 bus.start = 1'b0;
        push(0, 1'b0);
        wait_tick("w22");
        #1 bus.start = 1'b1;

        // reset at sec_cnt = 600 while running 128/s
        wait_tick("w23");
        repeat (600) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        #1 reset = 1'b0;
        push(0, 1'b0);
        push(128, 1'b0);
        wait_tick("w25");
        wait_tick("w26");
        #1 check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
